// File: rtl/per_lane_mem_ctrl_pkg.sv
// Shared lane-memory definitions: default geometry agreed by every lane
// instance and the DMA/fill path, plus the byte-merge helper used when
// a same-cycle write from the other port is forwarded to a reader.
package per_lane_mem_ctrl_pkg;

    localparam int LANE_AWIDTH    = 10;
    localparam int LANE_DWIDTH    = 32;
    localparam int LANE_NUM_WORDS = 1024;

    // Pick the forwarded write byte over the RAM byte when the other port wrote it.
    function automatic logic [7:0] byte_merge(
        input logic [7:0] ram_byte,
        input logic [7:0] fwd_byte,
        input logic       take_fwd
    );
        logic [7:0] res;
        if (take_fwd) begin
            res = fwd_byte;
        end else begin
            res = ram_byte;
        end
        return res;
    endfunction

endpackage

// File: rtl/per_lane_mem_ctrl_dpram.sv
// Simple dual-port RAM slice: two write ports, two registered read ports.
// Reads return the contents before any same-edge write (read-first); the
// controller above forwards same-cycle write data itself. Each read
// register only updates on its own read enable, so it holds between reads.
module per_lane_mem_ctrl_dpram #(
    parameter int AWIDTH    = 10,
    parameter int DWIDTH    = 8,
    parameter int NUM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic              re_a,
    input  logic [AWIDTH-1:0] addr_a,
    input  logic [DWIDTH-1:0] d_a,
    output logic [DWIDTH-1:0] q_a,
    input  logic              we_b,
    input  logic              re_b,
    input  logic [AWIDTH-1:0] addr_b,
    input  logic [DWIDTH-1:0] d_b,
    output logic [DWIDTH-1:0] q_b
);

    logic [DWIDTH-1:0] mem_r [NUM_WORDS];
    logic [DWIDTH-1:0] q_a_r;
    logic [DWIDTH-1:0] q_b_r;

    // Commit writes; port A is applied last so it wins any same-address tie.
    always_ff @(posedge clk) begin
        if (we_b) begin
            mem_r[addr_b] <= d_b;
        end
        if (we_a) begin
            mem_r[addr_a] <= d_a;
        end
    end

    // Registered reads, held until the next read on the same port.
    always_ff @(posedge clk) begin
        if (re_a) begin
            q_a_r <= mem_r[addr_a];
        end
        if (re_b) begin
            q_b_r <= mem_r[addr_b];
        end
    end

    assign q_a = q_a_r;
    assign q_b = q_b_r;

endmodule

// File: rtl/per_lane_mem_ctrl.sv
// Per-lane byte-writable dual-port memory. Port A serves the load/store unit,
// port B the DMA/fill path. Same-cycle cross-port read/write hazards are
// resolved by forwarding the writer's enabled bytes into the reader's result;
// write-write overlaps are resolved in favour of port A per byte.
module per_lane_mem_ctrl
    import per_lane_mem_ctrl_pkg::*;
#(
    parameter int AWIDTH    = LANE_AWIDTH,
    parameter int NUM_WORDS = LANE_NUM_WORDS,
    parameter int DWIDTH    = LANE_DWIDTH,
    parameter bit OUT_REG   = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [AWIDTH-1:0]     address_a,
    input  logic [AWIDTH-1:0]     address_b,
    input  logic                  rden_a,
    input  logic                  rden_b,
    input  logic                  wren_a,
    input  logic                  wren_b,
    input  logic [DWIDTH/8-1:0]   byteen_a,
    input  logic [DWIDTH/8-1:0]   byteen_b,
    input  logic [DWIDTH-1:0]     data_a,
    input  logic [DWIDTH-1:0]     data_b,
    output logic [DWIDTH-1:0]     out_a,
    output logic [DWIDTH-1:0]     out_b,
    output logic                  valid_a,
    output logic                  valid_b,
    output logic                  collision
);

    localparam int NUM_BYTES = DWIDTH / 8;
    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(NUM_WORDS);

    logic                  in_range_a_s, in_range_b_s, same_addr_s;
    logic                  wr_a_s, wr_b_s, rd_a_s, rd_b_s;
    logic                  re_ram_a_s, re_ram_b_s, collision_s;
    logic [NUM_BYTES-1:0]  we_a_vec_s, we_b_vec_s, fwd_mask_a_s, fwd_mask_b_s;
    logic [DWIDTH-1:0]     ram_q_a_s, ram_q_b_s;
    logic [DWIDTH-1:0]     fwd_merged_a_s, fwd_merged_b_s;
    logic [DWIDTH-1:0]     merged_a_s, merged_b_s;

    // First pipeline stage per port: valid, zero-result flag, forward mask/data.
    logic                  s1_valid_a_r, s1_valid_b_r;
    logic                  s1_zero_a_r, s1_zero_b_r;
    logic [NUM_BYTES-1:0]  s1_fmask_a_r, s1_fmask_b_r;
    logic [DWIDTH-1:0]     s1_fdata_a_r, s1_fdata_b_r;
    logic                  collision_r;

    assign in_range_a_s = ({1'b0, address_a} < DEPTH_C);
    assign in_range_b_s = ({1'b0, address_b} < DEPTH_C);
    assign same_addr_s  = (address_a == address_b);

    // Out-of-range writes are dropped; B loses every byte that A also writes.
    assign wr_a_s     = wren_a & in_range_a_s;
    assign wr_b_s     = wren_b & in_range_b_s;
    assign we_a_vec_s = byteen_a & {NUM_BYTES{wr_a_s}};
    assign we_b_vec_s = byteen_b & {NUM_BYTES{wr_b_s}}
                      & ~(we_a_vec_s & {NUM_BYTES{same_addr_s}});

    // A write on a port suppresses its own read request.
    assign rd_a_s     = rden_a & ~wren_a;
    assign rd_b_s     = rden_b & ~wren_b;
    assign re_ram_a_s = rd_a_s & in_range_a_s;
    assign re_ram_b_s = rd_b_s & in_range_b_s;

    // Bytes the other port writes to the read address this cycle.
    assign fwd_mask_a_s = we_b_vec_s & {NUM_BYTES{re_ram_a_s & same_addr_s}};
    assign fwd_mask_b_s = we_a_vec_s & {NUM_BYTES{re_ram_b_s & same_addr_s}};

    assign collision_s = wr_a_s & wr_b_s & same_addr_s & (|(byteen_a & byteen_b));

    for (genvar k = 0; k < NUM_BYTES; k++) begin : g_slice
        per_lane_mem_ctrl_dpram #(
            .AWIDTH    (AWIDTH),
            .DWIDTH    (8),
            .NUM_WORDS (NUM_WORDS)
        ) u_dpram (
            .clk    (clk),
            .we_a   (we_a_vec_s[k]),
            .re_a   (re_ram_a_s),
            .addr_a (address_a),
            .d_a    (data_a[k*8 +: 8]),
            .q_a    (ram_q_a_s[k*8 +: 8]),
            .we_b   (we_b_vec_s[k]),
            .re_b   (re_ram_b_s),
            .addr_b (address_b),
            .d_b    (data_b[k*8 +: 8]),
            .q_b    (ram_q_b_s[k*8 +: 8])
        );

        assign fwd_merged_a_s[k*8 +: 8] = byte_merge(ram_q_a_s[k*8 +: 8],
                                                     s1_fdata_a_r[k*8 +: 8],
                                                     s1_fmask_a_r[k]);
        assign fwd_merged_b_s[k*8 +: 8] = byte_merge(ram_q_b_s[k*8 +: 8],
                                                     s1_fdata_b_r[k*8 +: 8],
                                                     s1_fmask_b_r[k]);
    end

    // Port A request stage; reset forces a zero result until the next read.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_valid_a_r <= 1'b0;
            s1_zero_a_r  <= 1'b1;
            s1_fmask_a_r <= {NUM_BYTES{1'b0}};
            s1_fdata_a_r <= {DWIDTH{1'b0}};
        end else if (rd_a_s) begin
            s1_valid_a_r <= 1'b1;
            s1_zero_a_r  <= ~in_range_a_s;
            s1_fmask_a_r <= fwd_mask_a_s;
            s1_fdata_a_r <= data_b;
        end else begin
            s1_valid_a_r <= 1'b0;
        end
    end

    // Port B request stage; reset forces a zero result until the next read.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_valid_b_r <= 1'b0;
            s1_zero_b_r  <= 1'b1;
            s1_fmask_b_r <= {NUM_BYTES{1'b0}};
            s1_fdata_b_r <= {DWIDTH{1'b0}};
        end else if (rd_b_s) begin
            s1_valid_b_r <= 1'b1;
            s1_zero_b_r  <= ~in_range_b_s;
            s1_fmask_b_r <= fwd_mask_b_s;
            s1_fdata_b_r <= data_a;
        end else begin
            s1_valid_b_r <= 1'b0;
        end
    end

    // Final read word: zero for out-of-range or post-reset, else RAM merged with forward.
    always_comb begin
        if (s1_zero_a_r) begin
            merged_a_s = {DWIDTH{1'b0}};
        end else begin
            merged_a_s = fwd_merged_a_s;
        end
        if (s1_zero_b_r) begin
            merged_b_s = {DWIDTH{1'b0}};
        end else begin
            merged_b_s = fwd_merged_b_s;
        end
    end

    // Collision strobe, one cycle after the overlapping writes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            collision_r <= 1'b0;
        end else begin
            collision_r <= collision_s;
        end
    end

    assign collision = collision_r;

    if (OUT_REG) begin : g_out_reg
        logic [DWIDTH-1:0] s2_out_a_r, s2_out_b_r;
        logic              s2_valid_a_r, s2_valid_b_r;

        // Second stage: capture a completed read, hold otherwise.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                s2_valid_a_r <= 1'b0;
                s2_valid_b_r <= 1'b0;
                s2_out_a_r   <= {DWIDTH{1'b0}};
                s2_out_b_r   <= {DWIDTH{1'b0}};
            end else begin
                s2_valid_a_r <= s1_valid_a_r;
                s2_valid_b_r <= s1_valid_b_r;
                if (s1_valid_a_r) begin
                    s2_out_a_r <= merged_a_s;
                end
                if (s1_valid_b_r) begin
                    s2_out_b_r <= merged_b_s;
                end
            end
        end

        assign out_a   = s2_out_a_r;
        assign out_b   = s2_out_b_r;
        assign valid_a = s2_valid_a_r;
        assign valid_b = s2_valid_b_r;
    end else begin : g_no_out_reg
        assign out_a   = merged_a_s;
        assign out_b   = merged_b_s;
        assign valid_a = s1_valid_a_r;
        assign valid_b = s1_valid_b_r;
    end

endmodule

// File: tb/tb_per_lane_mem_ctrl.sv
// Scoreboard bench for per_lane_mem_ctrl. Two instances share the stimulus:
// dut0 without and dut1 with the output register stage. Expected read
// results (data and arrival cycle) are queued per stream; a negedge monitor
// pops and compares whenever a valid strobe appears.
module tb_per_lane_mem_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NB = 4;
    localparam int NW = 1000;

    logic          clk = 1'b0;
    logic          resetn;
    logic [AW-1:0] address_a, address_b;
    logic          rden_a, rden_b, wren_a, wren_b;
    logic [NB-1:0] byteen_a, byteen_b;
    logic [DW-1:0] data_a, data_b;
    logic [DW-1:0] out_a0, out_b0, out_a1, out_b1;
    logic          valid_a0, valid_b0, valid_a1, valid_b1;
    logic          coll0, coll1;

    always #5 clk = ~clk;

    per_lane_mem_ctrl #(.AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW), .OUT_REG(1'b0)) dut0 (
        .clk(clk), .resetn(resetn),
        .address_a(address_a), .address_b(address_b),
        .rden_a(rden_a), .rden_b(rden_b), .wren_a(wren_a), .wren_b(wren_b),
        .byteen_a(byteen_a), .byteen_b(byteen_b), .data_a(data_a), .data_b(data_b),
        .out_a(out_a0), .out_b(out_b0), .valid_a(valid_a0), .valid_b(valid_b0),
        .collision(coll0)
    );

    per_lane_mem_ctrl #(.AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW), .OUT_REG(1'b1)) dut1 (
        .clk(clk), .resetn(resetn),
        .address_a(address_a), .address_b(address_b),
        .rden_a(rden_a), .rden_b(rden_b), .wren_a(wren_a), .wren_b(wren_b),
        .byteen_a(byteen_a), .byteen_b(byteen_b), .data_a(data_a), .data_b(data_b),
        .out_a(out_a1), .out_b(out_b1), .valid_a(valid_a1), .valid_b(valid_b1),
        .collision(coll1)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } sb_entry_t;

    // Streams: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B.
    sb_entry_t   sbq [4][$];
    sb_entry_t   mon_e;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  vld_s;
    logic [31:0] outv_s [4];

    assign vld_s     = {valid_b1, valid_a1, valid_b0, valid_a0};
    assign outv_s[0] = out_a0;
    assign outv_s[1] = out_b0;
    assign outv_s[2] = out_a1;
    assign outv_s[3] = out_b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int p = 0; p < 4; p++) begin
            if (vld_s[p]) begin
                if (sbq[p].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid stream=%0d: got out=%h expected no valid", p, outv_s[p]);
                end else begin
                    mon_e = sbq[p].pop_front();
                    chk($sformatf("read_data_s%0d", p), outv_s[p], mon_e.data);
                    chk($sformatf("read_cycle_s%0d", p), cyc, mon_e.due);
                end
            end
        end
    end

    // Queue a read result for port (0=A, 1=B) on the selected instances.
    task automatic expect_rd(input int port, input logic [31:0] d, input logic [1:0] duts);
        if (duts[0]) sbq[port].push_back('{data: d, due: cyc + 1});
        if (duts[1]) sbq[2 + port].push_back('{data: d, due: cyc + 2});
    endtask

    task automatic drive(input logic wa, input logic ra, input logic [AW-1:0] aa,
                         input logic [NB-1:0] ba, input logic [DW-1:0] da,
                         input logic wb, input logic rb, input logic [AW-1:0] ab,
                         input logic [NB-1:0] bb, input logic [DW-1:0] db);
        wren_a = wa; rden_a = ra; address_a = aa; byteen_a = ba; data_a = da;
        wren_b = wb; rden_b = rb; address_b = ab; byteen_b = bb; data_b = db;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        wren_a = 1'b0; rden_a = 1'b0; address_a = '0; byteen_a = '0; data_a = '0;
        wren_b = 1'b0; rden_b = 1'b0; address_b = '0; byteen_b = '0; data_b = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam logic [AW-1:0] Z  = 10'd0;
    localparam logic [NB-1:0] NZ = 4'h0;
    localparam logic [DW-1:0] DZ = 32'h0;

    initial begin
        resetn = 1'b0;
        idle(3);
        chk("reset_out_a0", out_a0, 32'h0);
        chk("reset_out_b0", out_b0, 32'h0);
        chk("reset_out_a1", out_a1, 32'h0);
        chk("reset_out_b1", out_b1, 32'h0);
        chk("reset_valid0", {30'b0, valid_b0, valid_a0}, 32'h0);
        chk("reset_valid1", {30'b0, valid_b1, valid_a1}, 32'h0);
        chk("reset_coll", {30'b0, coll1, coll0}, 32'h0);
        resetn = 1'b1;
        idle(1);

        // Basic write then read, then hold across idle cycles.
        drive(1'b1, 1'b0, 10'd5, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, Z, NZ, DZ);
        expect_rd(0, 32'hDEADBEEF, 2'b11);
        drive(1'b0, 1'b1, 10'd5, NZ, DZ, 1'b0, 1'b0, Z, NZ, DZ);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk("hold_a0", out_a0, 32'hDEADBEEF);
            chk("hold_a1", out_a1, 32'hDEADBEEF);
        end

        // Byte enables.
        drive(1'b0, 1'b0, Z, NZ, DZ, 1'b1, 1'b0, 10'd7, 4'hF, 32'h11223344);
        drive(1'b1, 1'b0, 10'd7, 4'b0101, 32'hAABBCCDD, 1'b0, 1'b0, Z, NZ, DZ);
        expect_rd(1, 32'h11BB33DD, 2'b11);
        drive(1'b0, 1'b0, Z, NZ, DZ, 1'b0, 1'b1, 10'd7, NZ, DZ);

        // Cross-port forwarding B->A, then B overwrites while A idles.
        drive(1'b1, 1'b0, 10'd9, 4'hF, 32'h01020304, 1'b0, 1'b0, Z, NZ, DZ);
        expect_rd(0, 32'h01020355, 2'b11);
        drive(1'b0, 1'b1, 10'd9, NZ, DZ, 1'b1, 1'b0, 10'd9, 4'b0001, 32'h00000055);
        drive(1'b0, 1'b0, Z, NZ, DZ, 1'b1, 1'b0, 10'd9, 4'hF, 32'hFFFFFFFF);
        idle(2);
        chk("hold_after_b_write_a0", out_a0, 32'h01020355);
        chk("hold_after_b_write_a1", out_a1, 32'h01020355);
        // Forwarding A->B.
        expect_rd(1, 32'hFFFFAAFF, 2'b11);
        drive(1'b1, 1'b0, 10'd9, 4'b0010, 32'h0000AA00, 1'b0, 1'b1, 10'd9, NZ, DZ);

        // Write-write collision, overlapping byte 2.
        drive(1'b1, 1'b0, 10'd3, 4'hF, 32'h12345678, 1'b0, 1'b0, Z, NZ, DZ);
        drive(1'b1, 1'b0, 10'd3, 4'b1100, 32'hFFFF0000, 1'b1, 1'b0, 10'd3, 4'b0110, 32'h0000FFFF);
        chk("collision_pulse0", {31'b0, coll0}, 32'h1);
        chk("collision_pulse1", {31'b0, coll1}, 32'h1);
        idle(1);
        chk("collision_clear0", {31'b0, coll0}, 32'h0);
        chk("collision_clear1", {31'b0, coll1}, 32'h0);
        expect_rd(0, 32'hFFFFFF78, 2'b11);
        drive(1'b0, 1'b1, 10'd3, NZ, DZ, 1'b0, 1'b0, Z, NZ, DZ);

        // Write-write, same address, disjoint bytes: both land, no collision.
        drive(1'b1, 1'b0, 10'd4, 4'hF, 32'h0, 1'b0, 1'b0, Z, NZ, DZ);
        drive(1'b1, 1'b0, 10'd4, 4'b0001, 32'h000000AA, 1'b1, 1'b0, 10'd4, 4'b1000, 32'hBB000000);
        chk("no_collision0", {31'b0, coll0}, 32'h0);
        chk("no_collision1", {31'b0, coll1}, 32'h0);
        expect_rd(1, 32'hBB0000AA, 2'b11);
        drive(1'b0, 1'b0, Z, NZ, DZ, 1'b0, 1'b1, 10'd4, NZ, DZ);

        // Back-to-back reads, one result per cycle.
        expect_rd(0, 32'hDEADBEEF, 2'b11);
        expect_rd(1, 32'hFFFFAAFF, 2'b11);
        drive(1'b0, 1'b1, 10'd5, NZ, DZ, 1'b0, 1'b1, 10'd9, NZ, DZ);
        expect_rd(0, 32'h11BB33DD, 2'b11);
        drive(1'b0, 1'b1, 10'd7, NZ, DZ, 1'b0, 1'b0, Z, NZ, DZ);
        expect_rd(0, 32'hFFFFFF78, 2'b11);
        drive(1'b0, 1'b1, 10'd3, NZ, DZ, 1'b0, 1'b0, Z, NZ, DZ);

        // Read with write on the same port: write only, no valid.
        drive(1'b1, 1'b1, 10'd11, 4'hF, 32'h0BADF00D, 1'b0, 1'b0, Z, NZ, DZ);
        expect_rd(0, 32'h0BADF00D, 2'b11);
        drive(1'b0, 1'b1, 10'd11, NZ, DZ, 1'b0, 1'b0, Z, NZ, DZ);
        idle(3);

        // Reset with reads in flight.
        expect_rd(0, 32'hDEADBEEF, 2'b01);
        drive(1'b0, 1'b1, 10'd5, NZ, DZ, 1'b0, 1'b0, Z, NZ, DZ);
        resetn = 1'b0;
        drive(1'b0, 1'b1, 10'd3, NZ, DZ, 1'b0, 1'b1, 10'd7, NZ, DZ);
        idle(2);
        resetn = 1'b1;
        idle(1);
        chk("post_reset_out_a0", out_a0, 32'h0);
        chk("post_reset_out_b0", out_b0, 32'h0);
        chk("post_reset_out_a1", out_a1, 32'h0);
        chk("post_reset_out_b1", out_b1, 32'h0);
        expect_rd(0, 32'hDEADBEEF, 2'b11);
        expect_rd(1, 32'h11BB33DD, 2'b11);
        drive(1'b0, 1'b1, 10'd5, NZ, DZ, 1'b0, 1'b1, 10'd7, NZ, DZ);

        // Out-of-range addresses (NUM_WORDS = 1000); 999 is the last word.
        drive(1'b1, 1'b0, 10'd999, 4'hF, 32'hCAFEF00D, 1'b1, 1'b0, 10'd1001, 4'hF, 32'h12345678);
        expect_rd(0, 32'h0, 2'b11);
        expect_rd(1, 32'hCAFEF00D, 2'b11);
        drive(1'b0, 1'b1, 10'd1001, NZ, DZ, 1'b0, 1'b1, 10'd999, NZ, DZ);
        expect_rd(0, 32'h0, 2'b11);
        drive(1'b0, 1'b1, 10'd1001, NZ, DZ, 1'b1, 1'b0, 10'd1001, 4'hF, 32'h87654321);
        expect_rd(0, 32'hCAFEF00D, 2'b11);
        expect_rd(1, 32'hDEADBEEF, 2'b11);
        drive(1'b0, 1'b1, 10'd999, NZ, DZ, 1'b0, 1'b1, 10'd5, NZ, DZ);

        // Drain: bounded wait for all expected results.
        for (int i = 0; i < 10; i++) begin
            if (sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size() != 0) idle(1);
        end
        idle(2);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("drain_s%0d", p), sbq[p].size(), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
